// File: rtl/uart_wb_host_pkg.sv
// rtl/uart_wb_host_pkg.sv - shared types and constants for the Amber UART Wishbone host
// FSM states, flag register bit positions, init values and UART register offsets.
package uart_wb_host_pkg;

  typedef enum logic [2:0] {
    INIT_LCRH,
    INIT_LCRM,
    INIT_LCRL,
    INIT_CR,
    POLL_FR,
    WR_DR,
    RD_DR
  } state_t;

  localparam int FR_TXFE = 7;
  localparam int FR_RXFF = 6;
  localparam int FR_TXFF = 5;
  localparam int FR_RXFE = 4;

  // 8-bit words with FIFOs enabled; UART enabled with all interrupts masked
  localparam logic [7:0] LCRH_VALUE = 8'h70;
  localparam logic [7:0] CR_VALUE   = 8'h01;

  localparam logic [15:0] AMBER_UART_DR   = 16'h0000;
  localparam logic [15:0] AMBER_UART_LCRH = 16'h0008;
  localparam logic [15:0] AMBER_UART_LCRM = 16'h000c;
  localparam logic [15:0] AMBER_UART_LCRL = 16'h0010;
  localparam logic [15:0] AMBER_UART_CR   = 16'h0014;
  localparam logic [15:0] AMBER_UART_FR   = 16'h0018;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [15:0] offset);
    return base + {16'd0, offset};
  endfunction

endpackage

// File: rtl/wb_single_master.sv
// rtl/wb_single_master.sv - one-shot Wishbone access engine with ack timeout
// done/fail are combinational so the caller can act on the ack cycle itself.
module wb_single_master #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  output logic [31:0] wb_adr,
  output logic [3:0]  wb_sel,
  output logic        wb_we,
  output logic [31:0] wb_dat,
  input  logic [31:0] wb_rdat,
  output logic        wb_cyc,
  output logic        wb_stb,
  input  logic        wb_ack,
  input  logic        wb_err,
  output logic        done,
  output logic        fail,
  output logic [7:0]  rd_byte
);

  logic [7:0] wait_cnt;
  logic       unused_rdat;

  assign wb_sel      = 4'hf;
  assign rd_byte     = wb_rdat[7:0];
  assign unused_rdat = ^wb_rdat[31:8];
  assign done        = wb_cyc && wb_ack;
  // err and timeout both end the access without the data being trusted
  assign fail        = wb_cyc && !wb_ack && (wb_err || (wait_cnt == TIMEOUT - 8'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_we    <= 1'b0;
      wb_adr   <= 32'd0;
      wb_dat   <= 32'd0;
      wait_cnt <= 8'd0;
    end else if (wb_cyc) begin
      if (done || fail) begin
        wb_cyc <= 1'b0;
        wb_stb <= 1'b0;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end else if (req) begin
      wb_cyc   <= 1'b1;
      wb_stb   <= 1'b1;
      wb_we    <= req_we;
      wb_adr   <= req_adr;
      wb_dat   <= req_dat;
      wait_cnt <= 8'd0;
    end
  end

endmodule

// File: rtl/uart_wb_host.sv
// rtl/uart_wb_host.sv - programs an Amber UART, then shuttles bytes between streams and its DR
// Polls FR and services TX/RX with a 1-bit round-robin when both are ready.
module uart_wb_host
  import uart_wb_host_pkg::*;
#(
  parameter logic [31:0] UART_BASE = 32'h1600_0000,
  parameter logic [11:0] BAUD_DIV  = 12'd13,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic        i_tx_valid,
  input  logic [7:0]  i_tx_data,
  output logic        o_tx_ready,
  output logic        o_rx_valid,
  output logic [7:0]  o_rx_data,
  input  logic        i_rx_ready,
  output logic        o_init_done,
  output logic        o_error
);

  state_t      state;
  logic        pending;
  logic        req;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_dat;
  logic        done;
  logic        fail;
  logic [7:0]  rd_byte;
  logic [7:0]  tx_hold;
  logic        tx_hold_vld;
  logic        last_tx;
  logic        acc_we;
  logic [15:0] acc_off;
  logic [7:0]  acc_byte;
  logic        tx_pend;
  logic        rx_pend;

  assign o_tx_ready = o_init_done && !tx_hold_vld;
  assign tx_pend    = tx_hold_vld && !rd_byte[FR_TXFF];
  assign rx_pend    = !o_rx_valid && !rd_byte[FR_RXFE];

  always_comb begin
    acc_we   = 1'b1;
    acc_off  = AMBER_UART_DR;
    acc_byte = 8'd0;
    case (state)
      INIT_LCRH: begin acc_off = AMBER_UART_LCRH; acc_byte = LCRH_VALUE; end
      INIT_LCRM: begin acc_off = AMBER_UART_LCRM; acc_byte = {4'd0, BAUD_DIV[11:8]}; end
      INIT_LCRL: begin acc_off = AMBER_UART_LCRL; acc_byte = BAUD_DIV[7:0]; end
      INIT_CR:   begin acc_off = AMBER_UART_CR;   acc_byte = CR_VALUE; end
      POLL_FR:   begin acc_off = AMBER_UART_FR;   acc_we = 1'b0; end
      WR_DR:     acc_byte = tx_hold;
      RD_DR:     acc_we = 1'b0;
      default:   acc_we = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= INIT_LCRH;
      pending     <= 1'b0;
      req         <= 1'b0;
      req_we      <= 1'b0;
      req_adr     <= 32'd0;
      req_dat     <= 32'd0;
      tx_hold     <= 8'd0;
      tx_hold_vld <= 1'b0;
      o_rx_valid  <= 1'b0;
      o_rx_data   <= 8'd0;
      last_tx     <= 1'b1;
      o_init_done <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      req <= 1'b0;
      if (i_tx_valid && o_tx_ready) begin
        tx_hold     <= i_tx_data;
        tx_hold_vld <= 1'b1;
      end
      if (i_rx_ready && o_rx_valid)
        o_rx_valid <= 1'b0;

      if (!pending) begin
        pending <= 1'b1;
        req     <= 1'b1;
        req_we  <= acc_we;
        req_adr <= reg_addr(UART_BASE, acc_off);
        req_dat <= {24'd0, acc_byte};
      end else if (fail) begin
        // init writes retry in place; DR accesses fall back to a fresh FR poll
        o_error <= 1'b1;
        pending <= 1'b0;
        if (state == WR_DR || state == RD_DR)
          state <= POLL_FR;
      end else if (done) begin
        pending <= 1'b0;
        case (state)
          INIT_LCRH: state <= INIT_LCRM;
          INIT_LCRM: state <= INIT_LCRL;
          INIT_LCRL: state <= INIT_CR;
          INIT_CR: begin
            o_init_done <= 1'b1;
            state       <= POLL_FR;
          end
          POLL_FR: begin
            if (rx_pend && (!tx_pend || last_tx)) begin
              state   <= RD_DR;
              last_tx <= 1'b0;
            end else if (tx_pend) begin
              state   <= WR_DR;
              last_tx <= 1'b1;
            end
          end
          WR_DR: begin
            tx_hold_vld <= 1'b0;
            state       <= POLL_FR;
          end
          RD_DR: begin
            o_rx_data  <= rd_byte;
            o_rx_valid <= 1'b1;
            state      <= POLL_FR;
          end
          default: state <= POLL_FR;
        endcase
      end
    end
  end

  wb_single_master #(.TIMEOUT(TIMEOUT)) u_master (
    .clk     (i_clk),
    .rst     (i_rst),
    .req     (req),
    .req_we  (req_we),
    .req_adr (req_adr),
    .req_dat (req_dat),
    .wb_adr  (o_wb_adr),
    .wb_sel  (o_wb_sel),
    .wb_we   (o_wb_we),
    .wb_dat  (o_wb_dat),
    .wb_rdat (i_wb_dat),
    .wb_cyc  (o_wb_cyc),
    .wb_stb  (o_wb_stb),
    .wb_ack  (i_wb_ack),
    .wb_err  (i_wb_err),
    .done    (done),
    .fail    (fail),
    .rd_byte (rd_byte)
  );

endmodule

// File: tb/tb_uart_wb_host.sv
// tb/tb_uart_wb_host.sv - self-checking bench for uart_wb_host
// Behavioural UART slave on the bus; expectations come from bench-chosen bytes and the init table.
module tb_uart_wb_host;

  localparam logic [31:0] BASE    = 32'h1600_0000;
  localparam logic [31:0] A_DR    = BASE + 32'h00;
  localparam logic [31:0] A_LCRH  = BASE + 32'h08;
  localparam logic [31:0] A_LCRM  = BASE + 32'h0c;
  localparam logic [31:0] A_LCRL  = BASE + 32'h10;
  localparam logic [31:0] A_CR    = BASE + 32'h14;
  localparam logic [31:0] A_FR    = BASE + 32'h18;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] o_wb_adr;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic [31:0] o_wb_dat;
  logic [31:0] i_wb_dat = 32'd0;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_err = 1'b0;
  logic        i_tx_valid = 1'b0;
  logic [7:0]  i_tx_data = 8'd0;
  logic        o_tx_ready;
  logic        o_rx_valid;
  logic [7:0]  o_rx_data;
  logic        i_rx_ready = 1'b0;
  logic        o_init_done;
  logic        o_error;

  acc_t        all_log[$];
  acc_t        dr_log[$];
  logic [7:0]  tx_exp[$];
  int          cmp = 0;
  int          mis = 0;
  logic [7:0]  fr_value = 8'h10;
  logic [7:0]  dr_value = 8'h00;
  int          noack_writes = 0;
  int          stall_cycles = 0;
  int          timeout_len = 0;
  logic [31:0] stall_dat = 32'd0;
  logic [31:0] fail_dat = 32'd0;
  int          tx_left = 0;
  logic        prev_ready = 1'b0;

  always #5 clk = ~clk;

  uart_wb_host dut (
    .i_clk(clk), .i_rst(rst),
    .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we), .o_wb_dat(o_wb_dat),
    .i_wb_dat(i_wb_dat), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .i_wb_ack(i_wb_ack),
    .i_wb_err(i_wb_err), .i_tx_valid(i_tx_valid), .i_tx_data(i_tx_data), .o_tx_ready(o_tx_ready),
    .o_rx_valid(o_rx_valid), .o_rx_data(o_rx_data), .i_rx_ready(i_rx_ready),
    .o_init_done(o_init_done), .o_error(o_error)
  );

  // Slave: acks one cycle into each strobe unless a DR write is told to hang
  always @(negedge clk) begin
    i_wb_ack = 1'b0;
    if (o_wb_stb) begin
      if (o_wb_we && o_wb_adr == A_DR && noack_writes > 0) begin
        stall_cycles++;
        stall_dat = o_wb_dat;
      end else begin
        i_wb_ack = 1'b1;
        if (o_wb_adr == A_FR)      i_wb_dat = {24'd0, fr_value};
        else if (o_wb_adr == A_DR) i_wb_dat = {24'ha5a5a5, dr_value};
        else                       i_wb_dat = 32'd0;
      end
    end else if (stall_cycles > 0) begin
      timeout_len  = stall_cycles;
      fail_dat     = stall_dat;
      stall_cycles = 0;
      noack_writes--;
    end
  end

  always @(posedge clk) begin
    if (o_wb_stb && i_wb_ack) begin
      all_log.push_back('{o_wb_we, o_wb_adr, o_wb_dat});
      if (o_wb_adr == A_DR) dr_log.push_back('{o_wb_we, o_wb_adr, o_wb_dat});
    end
  end

  // TX producer: an accept happened on the last edge if valid was held while ready was seen
  always @(negedge clk) begin
    if (i_tx_valid && prev_ready) begin
      tx_exp.push_back(i_tx_data);
      i_tx_data = 8'($urandom);
      if (tx_left > 0) tx_left--;
    end
    i_tx_valid = (tx_left > 0);
    prev_ready = o_tx_ready;
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    cmp++; if (o_wb_cyc !== 1'b0)    begin mis++; $display("FAIL reset_cyc got %b want 0", o_wb_cyc); end
    cmp++; if (o_wb_stb !== 1'b0)    begin mis++; $display("FAIL reset_stb got %b want 0", o_wb_stb); end
    cmp++; if (o_wb_adr !== 32'd0)   begin mis++; $display("FAIL reset_adr got %h want 0", o_wb_adr); end
    cmp++; if (o_tx_ready !== 1'b0)  begin mis++; $display("FAIL reset_tx_ready got %b want 0", o_tx_ready); end
    cmp++; if (o_rx_valid !== 1'b0)  begin mis++; $display("FAIL reset_rx_valid got %b want 0", o_rx_valid); end
    cmp++; if (o_init_done !== 1'b0) begin mis++; $display("FAIL reset_init_done got %b want 0", o_init_done); end
    cmp++; if (o_error !== 1'b0)     begin mis++; $display("FAIL reset_error got %b want 0", o_error); end
  endtask

  task automatic test_init;
    logic [31:0] exp_adr[4];
    logic [31:0] exp_dat[4];
    bit          early;
    int          n;
    exp_adr = '{A_LCRH, A_LCRM, A_LCRL, A_CR};
    exp_dat = '{32'h70, 32'h00, 32'h0d, 32'h01};
    early = 0;
    n = 0;
    all_log.delete();
    rst = 1'b0;
    while (all_log.size() < 4 && n < 300) begin
      @(negedge clk);
      n++;
      if (all_log.size() < 4 && o_init_done) early = 1;
    end
    cmp++; if (all_log.size() != 4) begin mis++; $display("FAIL init_count got %0d want 4", all_log.size()); end
    cmp++; if (early) begin mis++; $display("FAIL init_done_early got 1 want 0 before 4th ack"); end
    cmp++; if (o_init_done !== 1'b1) begin mis++; $display("FAIL init_done got %b want 1", o_init_done); end
    for (int i = 0; i < 4 && i < all_log.size(); i++) begin
      cmp++;
      if (all_log[i].we !== 1'b1 || all_log[i].adr !== exp_adr[i] || all_log[i].dat !== exp_dat[i]) begin
        mis++;
        $display("FAIL init_write%0d got we=%b adr=%h dat=%h want we=1 adr=%h dat=%h",
                 i, all_log[i].we, all_log[i].adr, all_log[i].dat, exp_adr[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_tx;
    logic [7:0] b;
    int         n;
    fr_value = 8'h90;
    for (int k = 0; k < 5; k++) begin
      b = (k == 0) ? 8'h41 : 8'($urandom);
      dr_log.delete();
      i_tx_data = b;
      tx_left = 1;
      n = 0;
      while (dr_log.size() < 1 && n < 200) begin @(negedge clk); n++; end
      n = 0;
      while (o_tx_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      repeat (20) @(negedge clk);
      cmp++;
      if (dr_log.size() != 1) begin
        mis++; $display("FAIL tx_dr_count byte%0d got %0d want 1", k, dr_log.size());
      end else if (dr_log[0].we !== 1'b1 || dr_log[0].dat !== {24'd0, b}) begin
        mis++; $display("FAIL tx_dr_write byte%0d got we=%b dat=%h want we=1 dat=%h", k, dr_log[0].we, dr_log[0].dat, {24'd0, b});
      end
      cmp++; if (o_tx_ready !== 1'b1) begin mis++; $display("FAIL tx_ready_back byte%0d got %b want 1", k, o_tx_ready); end
    end
  endtask

  task automatic test_rx;
    logic [7:0] v;
    int         n;
    i_rx_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v = (k == 0) ? 8'h5a : 8'($urandom);
      dr_log.delete();
      dr_value = v;
      fr_value = 8'h80;
      n = 0;
      while (o_rx_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      cmp++; if (o_rx_valid !== 1'b1 || o_rx_data !== v) begin
        mis++; $display("FAIL rx_data%0d got valid=%b data=%h want valid=1 data=%h", k, o_rx_valid, o_rx_data, v);
      end
      repeat (40) @(negedge clk);
      cmp++; if (dr_log.size() != 1) begin mis++; $display("FAIL rx_single_read%0d got %0d reads want 1", k, dr_log.size()); end
      fr_value = 8'h10;
      repeat (10) @(negedge clk);
      i_rx_ready = 1'b1;
      @(negedge clk);
      i_rx_ready = 1'b0;
      cmp++; if (o_rx_valid !== 1'b0) begin mis++; $display("FAIL rx_consumed%0d got %b want 0", k, o_rx_valid); end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int w;
    dr_log.delete();
    tx_exp.delete();
    i_rx_ready = 1'b1;
    dr_value = 8'($urandom);
    fr_value = 8'h80;
    tx_left = 100;
    n = 0;
    while (dr_log.size() < 7 && n < 400) begin @(negedge clk); n++; end
    tx_left = 0;
    fr_value = 8'h10;
    repeat (40) @(negedge clk);
    i_rx_ready = 1'b0;
    cmp++; if (dr_log.size() < 7) begin mis++; $display("FAIL alt_count got %0d want >=7", dr_log.size()); end
    for (int i = 1; i < 7 && i < dr_log.size(); i++) begin
      cmp++;
      if (dr_log[i].we == dr_log[i-1].we) begin
        mis++; $display("FAIL alt_order%0d got we=%b after we=%b want alternation", i, dr_log[i].we, dr_log[i-1].we);
      end
    end
    w = 0;
    for (int i = 0; i < dr_log.size(); i++) begin
      if (dr_log[i].we && w < tx_exp.size()) begin
        cmp++;
        if (dr_log[i].dat !== {24'd0, tx_exp[w]}) begin
          mis++; $display("FAIL alt_tx_data%0d got %h want %h", w, dr_log[i].dat, {24'd0, tx_exp[w]});
        end
        w++;
      end
    end
  endtask

  task automatic test_timeout;
    logic [7:0] b;
    int         n;
    fr_value = 8'h90;
    cmp++; if (o_error !== 1'b0) begin mis++; $display("FAIL error_before_timeout got %b want 0", o_error); end
    b = 8'($urandom);
    dr_log.delete();
    timeout_len = 0;
    noack_writes = 1;
    i_tx_data = b;
    tx_left = 1;
    n = 0;
    while (dr_log.size() < 1 && n < 1000) begin @(negedge clk); n++; end
    cmp++; if (timeout_len != 255) begin mis++; $display("FAIL timeout_len got %0d want 255", timeout_len); end
    cmp++; if (fail_dat !== {24'd0, b}) begin mis++; $display("FAIL timeout_attempt_data got %h want %h", fail_dat, {24'd0, b}); end
    cmp++; if (o_error !== 1'b1) begin mis++; $display("FAIL timeout_error got %b want 1", o_error); end
    cmp++;
    if (dr_log.size() != 1) begin
      mis++; $display("FAIL timeout_retry_count got %0d want 1", dr_log.size());
    end else if (dr_log[0].we !== 1'b1 || dr_log[0].dat !== {24'd0, b}) begin
      mis++; $display("FAIL timeout_retry got we=%b dat=%h want we=1 dat=%h", dr_log[0].we, dr_log[0].dat, {24'd0, b});
    end
    fr_value = 8'h10;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    while (o_wb_stb !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    cmp++; if (o_wb_stb !== 1'b1) begin mis++; $display("FAIL midreset_stb_seen got %b want 1", o_wb_stb); end
    rst = 1'b1;
    all_log.delete();
    #1;
    cmp++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0) begin
      mis++; $display("FAIL midreset_bus got cyc=%b stb=%b want 0 0", o_wb_cyc, o_wb_stb);
    end
    cmp++; if (o_error !== 1'b0 || o_init_done !== 1'b0) begin
      mis++; $display("FAIL midreset_flags got error=%b init_done=%b want 0 0", o_error, o_init_done);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (all_log.size() < 1 && n < 50) begin @(negedge clk); n++; end
    cmp++;
    if (all_log.size() < 1) begin
      mis++; $display("FAIL midreset_restart got no access want LCRH write");
    end else if (all_log[0].we !== 1'b1 || all_log[0].adr !== A_LCRH || all_log[0].dat !== 32'h70) begin
      mis++; $display("FAIL midreset_restart got we=%b adr=%h dat=%h want we=1 adr=%h dat=70",
                      all_log[0].we, all_log[0].adr, all_log[0].dat, A_LCRH);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_tx();
    test_rx();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
